// File: rtl/stopwatch_ctrl_core_if.sv
// stopwatch_ctrl_core_if: command pulses in, run state and live/lap count out
interface stopwatch_ctrl_core_if #(parameter int CNT_W = 16);
  logic             start;
  logic             stop;
  logic             clear;
  logic             lap;
  logic             mode_down;
  logic [CNT_W-1:0] load_val;
  logic             run_enable;
  logic [1:0]       status;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lap_val;
  logic             lap_valid;
  logic             tick_o;
  logic             wrap_o;
  logic             done_o;
  modport master (
    output start, stop, clear, lap, mode_down, load_val,
    input  run_enable, status, count, lap_val, lap_valid, tick_o, wrap_o, done_o
  );
  modport slave (
    input  start, stop, clear, lap, mode_down, load_val,
    output run_enable, status, count, lap_val, lap_valid, tick_o, wrap_o, done_o
  );
endinterface

// File: rtl/stopwatch_ctrl_core.sv
// stopwatch_ctrl_core: up/down stopwatch FSM with tick prescaler, lap capture, wrap and expiry pulses
module stopwatch_ctrl_core #(
  parameter int CNT_W = 16,
  parameter int DIV   = 100
) (
  input logic                  clk,
  input logic                  rst_n,
  stopwatch_ctrl_core_if.slave sw
);
  localparam int DW = $clog2(DIV + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10, EXPIRED = 2'b11} state_t;
  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [CNT_W-1:0] count, lap_val;
  logic             mode_reg, lap_valid, tick_o, wrap_o, done_o;
  logic             tick, expire;
  assign tick   = (state == RUNNING) && (div_cnt == DW'(DIV - 1));
  assign expire = tick && mode_reg && (count == CNT_W'(1));
  assign sw.run_enable = (state == RUNNING);
  assign sw.status     = state;
  assign sw.count      = count;
  assign sw.lap_val    = lap_val;
  assign sw.lap_valid  = lap_valid;
  assign sw.tick_o     = tick_o;
  assign sw.wrap_o     = wrap_o;
  assign sw.done_o     = done_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      count     <= '0;
      lap_val   <= '0;
      mode_reg  <= 1'b0;
      lap_valid <= 1'b0;
      tick_o    <= 1'b0;
      wrap_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      wrap_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          count   <= '0;
          div_cnt <= '0;
          if (sw.clear) lap_valid <= 1'b0;
          else if (sw.start) begin
            mode_reg <= sw.mode_down;
            if (sw.mode_down && sw.load_val == '0) begin
              state  <= EXPIRED;
              done_o <= 1'b1;
            end else begin
              count <= sw.mode_down ? sw.load_val : '0;
              state <= RUNNING;
            end
          end
        end
        RUNNING: begin
          if (sw.clear) begin
            state     <= IDLE;
            count     <= '0;
            div_cnt   <= '0;
            lap_valid <= 1'b0;
          end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
              tick_o <= 1'b1;
              count  <= mode_reg ? count - 1'b1 : count + 1'b1;
              wrap_o <= !mode_reg && (&count);
            end
            // expiry wins over a coincident stop so the count never parks at 0 in PAUSED
            if (expire) begin
              state  <= EXPIRED;
              done_o <= 1'b1;
            end else if (sw.stop) state <= PAUSED;
            if (!sw.stop && sw.lap) begin
              lap_val   <= count;
              lap_valid <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (sw.clear) begin
            state     <= IDLE;
            count     <= '0;
            div_cnt   <= '0;
            lap_valid <= 1'b0;
          end else if (sw.start) state <= RUNNING;
        end
        EXPIRED: begin
          count   <= '0;
          div_cnt <= '0;
          if (sw.clear) begin
            state     <= IDLE;
            lap_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
